// File: rtl/rgb_pkg.sv
// rtl/rgb_pkg.sv - shared fade states, colour widths and tick-divisor helpers
package rgb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } fade_state_t;

  localparam int RGB_W   = 8;
  localparam int COLOR_W = 24;

  function automatic int tick_div(input int clk_freq, input int step_freq);
    return clk_freq / step_freq;
  endfunction

  // Width of a counter that has to reach div-1.
  function automatic int tick_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/rgb_fade_controller_if.sv
// rtl/rgb_fade_controller_if.sv - target handshake, abort and duty-reference bundle
interface rgb_fade_controller_if;

  logic                          tgt_valid;
  logic                          tgt_ready;
  logic [rgb_pkg::COLOR_W-1:0]   tgt_rgb;
  logic                          abort;
  logic [rgb_pkg::RGB_W-1:0]     pwm_ref_r;
  logic [rgb_pkg::RGB_W-1:0]     pwm_ref_g;
  logic [rgb_pkg::RGB_W-1:0]     pwm_ref_b;
  logic                          busy;
  logic                          done;

  modport master (
    output tgt_valid, tgt_rgb, abort,
    input  tgt_ready, pwm_ref_r, pwm_ref_g, pwm_ref_b, busy, done
  );

  modport slave (
    input  tgt_valid, tgt_rgb, abort,
    output tgt_ready, pwm_ref_r, pwm_ref_g, pwm_ref_b, busy, done
  );

endinterface

// File: rtl/rgb_fade_controller_tick_gen.sv
// rtl/rgb_fade_controller_tick_gen.sv - step-tick prescaler, re-phased by clear
module tick_gen
  import rgb_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int STEP_FREQ = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int DIV = tick_div(CLK_FREQ, STEP_FREQ);
  localparam int CW  = tick_cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_fade_controller.sv
// rtl/rgb_fade_controller.sv - ramps three PWM duty references toward a target colour
module rgb_fade_controller
  import rgb_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int STEP_FREQ  = 1000,
  parameter int HOLD_TICKS = 250
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rgb_fade_controller_if.slave  bus
);

  localparam int HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int HOLD_LAST = (HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0;

  fade_state_t              state_q, state_d;
  logic [COLOR_W-1:0]       tgt_q, tgt_d;
  logic [COLOR_W-1:0]       cur_q, cur_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     done_q;
  logic                     accept;
  logic                     tick;

  function automatic logic [RGB_W-1:0] step_toward(input logic [RGB_W-1:0] cur,
                                                   input logic [RGB_W-1:0] tgt);
    if (cur < tgt) return cur + 1'b1;
    if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

  assign accept = bus.tgt_valid && (state_q == IDLE);

  tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .STEP_FREQ (STEP_FREQ)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tgt_d   = bus.tgt_rgb;
          hold_d  = '0;
          state_d = FADE;
        end
      end
      FADE: begin
        // A tick landing in the abort cycle still moves the references.
        if (tick) begin
          for (int c = 0; c < 3; c++) begin
            cur_d[c*RGB_W +: RGB_W] = step_toward(cur_q[c*RGB_W +: RGB_W],
                                                  tgt_q[c*RGB_W +: RGB_W]);
          end
        end
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cur_q == tgt_q) begin
          state_d = (HOLD_TICKS > 0) ? HOLD : DONE;
        end
      end
      HOLD: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (tick) begin
          if (hold_q == HOLD_W'(HOLD_LAST)) begin
            state_d = DONE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      cur_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cur_q   <= cur_d;
      hold_q  <= hold_d;
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.tgt_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.pwm_ref_r = cur_q[23:16];
  assign bus.pwm_ref_g = cur_q[15:8];
  assign bus.pwm_ref_b = cur_q[7:0];

endmodule

// File: doc/rgb_fade_controller.md
# rgb_fade_controller

Sequencer that drives the three 8-bit PWM duty references of the RGB mixer datapath, so the PWM generators see smooth colour transitions instead of jumps. A 24-bit target colour arrives over a valid/ready handshake. Each channel ramps toward its target by one LSB per step tick, holds the colour for a programmable number of ticks, then signals completion. The block sits in front of the PWM instances and replaces the manual inc/dec counter path when automatic fades are selected.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- STEP_FREQ, 1000, step-tick rate in Hz; TICK_DIV = CLK_FREQ/STEP_FREQ, must be ≥ 2
- HOLD_TICKS, 250, ticks to hold the reached colour; 0 skips HOLD
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- tgt_valid  input  1  target colour valid
- tgt_ready  output  1  high only in IDLE
- tgt_rgb  input  24  target colour {R[23:16], G[15:8], B[7:0]}
- abort  input  1  synchronous cancel of the current fade/hold
- pwm_ref_r / pwm_ref_g / pwm_ref_b  output  8 each  current duty references
- busy  output  1  state ≠ IDLE
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, FADE, HOLD, DONE.
- Accept: tgt_valid && tgt_ready in IDLE.
  - Register tgt_rgb, clear the tick counter and hold counter, go to FADE.
- FADE:
  - On each tick, every channel with cur < tgt increments by 1, with cur > tgt decrements by 1, and is otherwise unchanged.
  - All three channels move in the same cycle.
  - When all channels equal their targets (registered compare, tick not required), go to HOLD if HOLD_TICKS > 0, else go to DONE.
- HOLD: count ticks; on the HOLD_TICKS-th tick go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- abort:
  - In FADE or HOLD: next state IDLE, references freeze at their current values, no done pulse.
  - In IDLE or DONE: ignored.
- tgt_valid while not IDLE: not accepted; tgt_rgb is not sampled.
- Channels never wrap. Each step is ±1 toward the target, so 0x00 and 0xFF are never overshot.
- Fade duration in ticks = max over channels of |tgt − cur|.

## Timing
- Reset (async assert, sync release):
  - state IDLE
  - pwm_ref_r/g/b = 0x00
  - tick counter and hold counter = 0
  - done = 0, busy = 0, tgt_ready = 1
- tgt_ready and busy are decoded directly from the state register.
- Accept at cycle A:
  - state = FADE at A+1.
  - The tick counter counts from 0 starting at A+1. A tick fires when the counter reaches TICK_DIV−1, then the counter wraps to 0.
  - First tick at A+TICK_DIV; its reference update is visible at A+TICK_DIV+1.
- A target equal to the current colour: FADE lasts 1 cycle.
- Hold counter:
  - Counts only in HOLD.
  - The tick counter keeps running across the FADE→HOLD boundary and is not re-phased.
- done is registered and high in the DONE cycle. tgt_ready goes high in the cycle after done.
- abort in cycle X: state = IDLE and tgt_ready = 1 at X+1. A reference update scheduled for X by a tick still takes effect.

## Structure
- Shared package (rgb_pkg):
  - fade_state_t enum {IDLE, FADE, HOLD, DONE}
  - RGB_W = 8 and COLOR_W = 24 constants
  - a tick-divisor helper computing TICK_DIV and its counter width $clog2(TICK_DIV)
- Sub-module tick_gen:
  - Ports: clk, rst_n, clear, tick.
  - Prescaler parameterised by CLK_FREQ/STEP_FREQ.
  - clear is driven on accept.
- Channel step logic: one per-channel function or generate loop, not a separate module.

## Test plan
- Reset with CLK_FREQ=1000, STEP_FREQ=100 (TICK_DIV=10), HOLD_TICKS=2:
  - rst_n low mid-fade -> all refs 0x00, tgt_ready=1, busy=0, done=0 immediately (asynchronous).
- Accept 0x0A0503 from black:
  - R ramps +1 every 10 cycles and reaches 0x0A at A+101.
  - G holds at 0x05 from A+51.
  - B holds at 0x03 from A+31.
  - HOLD lasts 2 ticks, single done pulse, then tgt_ready=1.
- Downward and clamp:
  - from 0xFF00FF, target 0x00FF00 -> 255 ticks.
  - All channels cross symmetrically.
  - No wrap; final value exactly 0x00FF00.
- Equal target:
  - accept a target equal to the current colour -> FADE one cycle, then HOLD, done after 2 ticks.
  - With HOLD_TICKS=0, done at A+2.
- abort mid-FADE at R=0x04 -> IDLE next cycle, R stays 0x04, no done pulse; the next accept resumes from 0x04.
- Back-pressure: tgt_valid held high with a new value during FADE -> not accepted until IDLE; the value present at acceptance is the one registered.
